// File: rtl/fc_pe_feeder.sv
// Input sequencer for the FC processing element: buffers the feature vector on group 0,
// replays it for every later 16-neuron group and inserts the 3-slice accumulator drain.
module fc_pe_feeder #(
  parameter int FEAT_DEPTH = 256,
  parameter int GRP_W      = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(FEAT_DEPTH)-1:0] num_words_m1,
  input  logic [GRP_W-1:0]              num_groups_m1,
  input  logic [111:0]                  feat_in,
  input  logic                          feat_valid,
  output logic                          feat_ready,
  input  logic [143:0]                  wgt_in,
  input  logic                          wgt_valid,
  output logic                          wgt_ready,
  output logic [143:0]                  weight,
  output logic [111:0]                  feature,
  output logic [1:0]                    weight_control,
  output logic [2:0]                    output_en_line,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(FEAT_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, REPLAY, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    n_m1_q, word_q;
  logic [GRP_W-1:0] g_m1_q, grp_q;
  logic [1:0]       drn_q;
  logic             beat, last_word, last_drain;

  logic [111:0]     mem [FEAT_DEPTH];
  logic [111:0]     feat_q, rd_q;
  logic             src_rep;

  // LOAD needs both streams in the same cycle; REPLAY only consumes weights.
  assign beat       = (state_q == LOAD && feat_valid && wgt_valid) ||
                      (state_q == REPLAY && wgt_valid);
  assign last_word  = (word_q == n_m1_q);
  assign last_drain = (drn_q == 2'd3);

  assign feat_ready = (state_q == LOAD) && wgt_valid;
  assign wgt_ready  = ((state_q == LOAD) && feat_valid) || (state_q == REPLAY);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign feature    = src_rep ? rd_q : feat_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (start) state_d = LOAD;
      LOAD, REPLAY: if (beat && last_word) state_d = DRAIN;
      DRAIN:        if (last_drain) state_d = (grp_q != g_m1_q) ? REPLAY : FIN;
      FIN:          state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_m1_q  <= '0;
      g_m1_q  <= '0;
      word_q  <= '0;
      grp_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          n_m1_q <= num_words_m1;
          g_m1_q <= num_groups_m1;
          word_q <= '0;
          grp_q  <= '0;
        end
        LOAD, REPLAY: if (beat) word_q <= word_q + AW'(1);
        DRAIN: begin
          // 2-bit drain counter wraps back to 0 as the state leaves DRAIN
          drn_q <= drn_q + 2'd1;
          if (last_drain && grp_q != g_m1_q) begin
            grp_q  <= grp_q + GRP_W'(1);
            word_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // PE-facing registers: one-cycle latency from beat to PE inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight         <= '0;
      feat_q         <= '0;
      src_rep        <= 1'b0;
      weight_control <= 2'b00;
      output_en_line <= 3'b000;
    end else begin
      weight_control <= 2'b00;
      if (beat) begin
        weight         <= wgt_in;
        src_rep        <= (state_q == REPLAY);
        weight_control <= (word_q == '0) ? 2'b01 : 2'b10;
        if (state_q == LOAD) feat_q <= feat_in;
      end
      output_en_line <= 3'b000;
      if (state_q == DRAIN) begin
        case (drn_q)
          2'd0:    output_en_line <= 3'b001;
          2'd1:    output_en_line <= 3'b010;
          2'd2:    output_en_line <= 3'b100;
          default: output_en_line <= 3'b000;
        endcase
      end
    end
  end

  // Feature buffer: written only in LOAD, read synchronously only in REPLAY.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && beat)   mem[word_q] <= feat_in;
    if (state_q == REPLAY && beat) rd_q <= mem[word_q];
  end

endmodule

// File: tb/tb_fc_pe_feeder.sv
// Randomized bench for fc_pe_feeder against a queue-based model of the PE beat stream.
module tb_fc_pe_feeder;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]   num_words_m1 = '0;
  logic [11:0]  num_groups_m1 = '0;
  logic [111:0] feat_in;
  logic         feat_valid, feat_ready;
  logic [143:0] wgt_in;
  logic         wgt_valid, wgt_ready;
  logic [143:0] weight;
  logic [111:0] feature;
  logic [1:0]   weight_control;
  logic [2:0]   output_en_line;
  logic         busy, done;

  fc_pe_feeder #(.FEAT_DEPTH(256), .GRP_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_words_m1(num_words_m1), .num_groups_m1(num_groups_m1),
    .feat_in(feat_in), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .weight(weight), .feature(feature), .weight_control(weight_control),
    .output_en_line(output_en_line), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // upstream stream sources
  logic [111:0] fq[$];
  logic [143:0] wq[$];
  int fgap = 0, wgap = 0, fpops = 0, wpops = 0;
  int wfire[$];

  // model expectations
  logic [111:0] exp_f[$];
  logic [143:0] exp_w[$];
  logic [1:0]   exp_c[$];

  // observations
  logic [1:0]   obs_c[$];
  logic [143:0] obs_w[$];
  logic [111:0] obs_f[$];
  int obs_cyc[$], oel_cyc[$], done_cyc[$], rise_cyc[$], fall_cyc[$];
  logic [2:0] oel_val[$];
  int overlap = 0, rdy_drain = 0, bad_wc = 0;
  logic prev_busy = 1'b0;

  function automatic logic [111:0] rnd_f();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[111:0];
  endfunction

  function automatic logic [143:0] rnd_w();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[143:0];
  endfunction

  initial begin
    logic ff, wf;
    logic [111:0] tf;
    logic [143:0] tw;
    int c;
    feat_valid = 1'b0; wgt_valid = 1'b0; feat_in = '0; wgt_in = '0;
    forever begin
      @(negedge clk);
      feat_valid = (fq.size() > 0) && ($urandom_range(99) >= fgap);
      feat_in    = (fq.size() > 0) ? fq[0] : '0;
      wgt_valid  = (wq.size() > 0) && ($urandom_range(99) >= wgap);
      wgt_in     = (wq.size() > 0) ? wq[0] : '0;
      #1;
      ff = feat_valid && feat_ready;
      wf = wgt_valid && wgt_ready;
      c  = cyc;
      @(posedge clk);
      if (ff && fq.size() > 0) begin tf = fq.pop_front(); fpops++; end
      if (wf && wq.size() > 0) begin tw = wq.pop_front(); wpops++; wfire.push_back(c); end
    end
  end

  initial forever begin
    @(negedge clk);
    if (weight_control != 2'b00) begin
      obs_c.push_back(weight_control); obs_w.push_back(weight);
      obs_f.push_back(feature); obs_cyc.push_back(cyc);
    end
    if (output_en_line != 3'b000) begin
      oel_cyc.push_back(cyc); oel_val.push_back(output_en_line);
      if (feat_ready || wgt_ready) rdy_drain++;
    end
    if (weight_control != 2'b00 && output_en_line != 3'b000) overlap++;
    if (weight_control == 2'b11) bad_wc++;
    if (done) done_cyc.push_back(cyc);
    if (busy && !prev_busy) rise_cyc.push_back(cyc);
    if (!busy && prev_busy) fall_cyc.push_back(cyc);
    prev_busy = busy;
  end

  task automatic clear_obs();
    obs_c.delete(); obs_w.delete(); obs_f.delete(); obs_cyc.delete();
    oel_cyc.delete(); oel_val.delete(); done_cyc.delete();
    rise_cyc.delete(); fall_cyc.delete(); wfire.delete();
    exp_f.delete(); exp_w.delete(); exp_c.delete();
    overlap = 0; rdy_drain = 0; bad_wc = 0; fpops = 0; wpops = 0;
  endtask

  // Builds the expected PE stream from the job definition and runs the job to done.
  task automatic run_job(input int n, input int g, input int fg, input int wg,
                         input bit hold, input bit extra, output int s, output int tmo);
    logic [111:0] fw[$];
    logic [143:0] ww[$];
    int k;
    @(negedge clk);
    clear_obs();
    fq.delete(); wq.delete();
    for (int i = 0; i < n; i++) fw.push_back(rnd_f());
    for (int i = 0; i < n * g; i++) ww.push_back(rnd_w());
    for (int gi = 0; gi < g; gi++)
      for (int i = 0; i < n; i++) begin
        exp_f.push_back(fw[i]); exp_w.push_back(ww[gi * n + i]);
        exp_c.push_back(i == 0 ? 2'b01 : 2'b10);
      end
    foreach (fw[i]) fq.push_back(fw[i]);
    foreach (ww[i]) wq.push_back(ww[i]);
    if (extra) fq.push_back(rnd_f());
    fgap = fg; wgap = wg;
    num_words_m1 = 8'(n - 1); num_groups_m1 = 12'(g - 1);
    start = 1'b1; s = cyc;
    @(negedge clk);
    if (hold) num_words_m1 = 8'(n + 2);
    else start = 1'b0;
    k = 0;
    while (!done && k < 20000) begin @(negedge clk); k++; end
    start = 1'b0;
    tmo = (k >= 20000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (weight !== '0) begin n_fail++; $display("FAIL reset_weight got %0h want 0", weight); end
    n_chk++; if (feature !== '0) begin n_fail++; $display("FAIL reset_feature got %0h want 0", feature); end
    n_chk++; if (weight_control !== 2'b00) begin n_fail++; $display("FAIL reset_wc got %b want 00", weight_control); end
    n_chk++; if (output_en_line !== 3'b000) begin n_fail++; $display("FAIL reset_oel got %b want 000", output_en_line); end
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    n_chk++; if ({feat_ready, wgt_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {feat_ready, wgt_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int s, tmo;
    run_job(1, 1, 0, 0, 0, 0, s, tmo);
    n_chk++; if (tmo != 0) begin n_fail++; $display("FAIL single_timeout got %0d want 0", tmo); end
    n_chk++; if (rise_cyc.size() != 1 || rise_cyc[0] != s + 1) begin n_fail++; $display("FAIL single_busy_rise got %p want %0d", rise_cyc, s + 1); end
    n_chk++; if (obs_cyc.size() != 1 || obs_cyc[0] != s + 2 || obs_c[0] !== 2'b01) begin
      n_fail++; $display("FAIL single_beat got cycles %p codes %p want %0d/01", obs_cyc, obs_c, s + 2); end
    n_chk++; if (obs_f.size() != 1 || obs_f[0] !== exp_f[0] || obs_w[0] !== exp_w[0]) begin
      n_fail++; $display("FAIL single_data got %p want %h", obs_f, exp_f[0]); end
    n_chk++; if (oel_cyc.size() != 3 || oel_cyc[0] != s + 3 || oel_cyc[2] != s + 5 ||
                 oel_val[0] !== 3'b001 || oel_val[1] !== 3'b010 || oel_val[2] !== 3'b100) begin
      n_fail++; $display("FAIL single_drain got %p/%p want %0d..%0d 1,2,4", oel_cyc, oel_val, s + 3, s + 5); end
    n_chk++; if (done_cyc.size() != 1 || done_cyc[0] != s + 6) begin n_fail++; $display("FAIL single_done got %p want %0d", done_cyc, s + 6); end
    n_chk++; if (fall_cyc.size() != 1 || fall_cyc[0] != s + 7) begin n_fail++; $display("FAIL single_busy_fall got %p want %0d", fall_cyc, s + 7); end
  endtask

  task automatic test_groups();
    int s, tmo, l;
    logic [2:0] ev;
    run_job(4, 3, 0, 0, 0, 1, s, tmo);
    n_chk++; if (tmo != 0) begin n_fail++; $display("FAIL groups_timeout got %0d want 0", tmo); end
    n_chk++; if (obs_c.size() != 12 || oel_cyc.size() != 9 || wfire.size() != 12) begin
      n_fail++; $display("FAIL groups_counts got %0d beats %0d drains want 12 9", obs_c.size(), oel_cyc.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        n_chk++; if (obs_f[i] !== exp_f[i] || obs_w[i] !== exp_w[i] || obs_c[i] !== exp_c[i]) begin
          n_fail++; $display("FAIL groups_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_f[i], obs_w[i], obs_c[i], exp_f[i], exp_w[i], exp_c[i]); end
        n_chk++; if (obs_cyc[i] != wfire[i] + 1) begin n_fail++; $display("FAIL groups_latency%0d got %0d want %0d", i, obs_cyc[i], wfire[i] + 1); end
      end
      for (int g = 0; g < 3; g++) begin
        l = obs_cyc[g * 4 + 3];
        for (int k = 0; k < 3; k++) begin
          ev = 3'b001 << k;
          n_chk++; if (oel_cyc[g * 3 + k] != l + 1 + k || oel_val[g * 3 + k] !== ev) begin
            n_fail++; $display("FAIL groups_drain%0d_%0d got %0d/%b want %0d/%b", g, k, oel_cyc[g * 3 + k], oel_val[g * 3 + k], l + 1 + k, ev); end
        end
        if (g < 2) begin
          n_chk++; if (obs_cyc[g * 4 + 4] < l + 4) begin n_fail++; $display("FAIL groups_next%0d got %0d want >=%0d", g, obs_cyc[g * 4 + 4], l + 4); end
        end
      end
      n_chk++; if (done_cyc.size() != 1 || done_cyc[0] != obs_cyc[11] + 4) begin
        n_fail++; $display("FAIL groups_done got %p want %0d", done_cyc, obs_cyc[11] + 4); end
      n_chk++; if (fall_cyc.size() != 1 || fall_cyc[0] != obs_cyc[11] + 5) begin
        n_fail++; $display("FAIL groups_busy_fall got %p want %0d", fall_cyc, obs_cyc[11] + 5); end
    end
    n_chk++; if (fpops != 4 || fq.size() != 1 || wpops != 12) begin
      n_fail++; $display("FAIL groups_consume got f%0d left%0d w%0d want f4 left1 w12", fpops, fq.size(), wpops); end
    n_chk++; if (overlap != 0 || rdy_drain != 0 || bad_wc != 0) begin
      n_fail++; $display("FAIL groups_order got overlap %0d rdy %0d wc11 %0d want 0", overlap, rdy_drain, bad_wc); end
    fq.delete();
  endtask

  task automatic test_random_gaps();
    int s, tmo, l;
    run_job(8, 2, 35, 40, 0, 0, s, tmo);
    n_chk++; if (tmo != 0) begin n_fail++; $display("FAIL gaps_timeout got %0d want 0", tmo); end
    n_chk++; if (obs_c.size() != 16 || wfire.size() != 16 || oel_cyc.size() != 6) begin
      n_fail++; $display("FAIL gaps_counts got %0d beats %0d fires %0d drains want 16 16 6", obs_c.size(), wfire.size(), oel_cyc.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_chk++; if (obs_f[i] !== exp_f[i] || obs_w[i] !== exp_w[i] || obs_c[i] !== exp_c[i] || obs_cyc[i] != wfire[i] + 1) begin
          n_fail++; $display("FAIL gaps_beat%0d got %h/%h/%b@%0d want %h/%h/%b@%0d", i, obs_f[i], obs_w[i], obs_c[i], obs_cyc[i], exp_f[i], exp_w[i], exp_c[i], wfire[i] + 1); end
      end
      l = obs_cyc[7];
      n_chk++; if (oel_cyc[0] != l + 1 || oel_cyc[2] != l + 3 || obs_cyc[8] < l + 4) begin
        n_fail++; $display("FAIL gaps_drain got %0d..%0d next %0d want %0d..%0d next>=%0d", oel_cyc[0], oel_cyc[2], obs_cyc[8], l + 1, l + 3, l + 4); end
    end
    n_chk++; if (fpops != 8 || wpops != 16 || overlap != 0 || rdy_drain != 0) begin
      n_fail++; $display("FAIL gaps_consume got f%0d w%0d ov%0d rdy%0d want 8 16 0 0", fpops, wpops, overlap, rdy_drain); end
  endtask

  task automatic test_start_ignored();
    int s, tmo;
    run_job(3, 2, 0, 0, 1, 0, s, tmo);
    n_chk++; if (tmo != 0) begin n_fail++; $display("FAIL hold_timeout got %0d want 0", tmo); end
    n_chk++; if (done_cyc.size() != 1 || rise_cyc.size() != 1) begin
      n_fail++; $display("FAIL hold_done got %0d dones %0d jobs want 1 1", done_cyc.size(), rise_cyc.size()); end
    n_chk++; if (obs_c.size() != 6 || wpops != 6) begin n_fail++; $display("FAIL hold_beats got %0d/%0d want 6", obs_c.size(), wpops); end
    else for (int i = 0; i < 6; i++) begin
      n_chk++; if (obs_f[i] !== exp_f[i] || obs_w[i] !== exp_w[i] || obs_c[i] !== exp_c[i]) begin
        n_fail++; $display("FAIL hold_beat%0d got %h/%b want %h/%b", i, obs_f[i], obs_c[i], exp_f[i], exp_c[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int k, s, tmo;
    @(negedge clk);
    clear_obs();
    fq.delete(); wq.delete();
    for (int i = 0; i < 8; i++) begin fq.push_back(rnd_f()); wq.push_back(rnd_w()); end
    fgap = 0; wgap = 0;
    num_words_m1 = 8'd7; num_groups_m1 = 12'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (obs_c.size() < 3 && k < 100) begin @(negedge clk); k++; end
    n_chk++; if (obs_c.size() != 3) begin n_fail++; $display("FAIL rst_setup got %0d beats want 3", obs_c.size()); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done, feat_ready, wgt_ready} !== 4'b0000 || weight_control !== 2'b00 || output_en_line !== 3'b000) begin
      n_fail++; $display("FAIL rst_async_ctrl got %b %b %b want 0000 00 000", {busy, done, feat_ready, wgt_ready}, weight_control, output_en_line); end
    n_chk++; if (weight !== '0 || feature !== '0) begin n_fail++; $display("FAIL rst_async_data got %h %h want 0 0", weight, feature); end
    @(negedge clk); fq.delete(); wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++; if (obs_c.size() != 3 || done_cyc.size() != 0 || oel_cyc.size() != 0) begin
      n_fail++; $display("FAIL rst_abort got %0d beats %0d done %0d drains want 3 0 0", obs_c.size(), done_cyc.size(), oel_cyc.size()); end
    run_job(2, 1, 0, 0, 0, 0, s, tmo);
    n_chk++; if (tmo != 0 || done_cyc.size() != 1 || obs_c.size() != 2) begin
      n_fail++; $display("FAIL rst_rerun got tmo%0d done%0d beats%0d want 0 1 2", tmo, done_cyc.size(), obs_c.size()); end
    else begin
      n_chk++; if (obs_f[0] !== exp_f[0] || obs_f[1] !== exp_f[1] || obs_w[1] !== exp_w[1] || obs_c[0] !== 2'b01 || obs_c[1] !== 2'b10) begin
        n_fail++; $display("FAIL rst_rerun_data got %h/%h want %h/%h", obs_f[0], obs_f[1], exp_f[0], exp_f[1]); end
    end
  endtask

  task automatic test_full_depth();
    int s, tmo, bad;
    run_job(256, 2, 0, 0, 0, 0, s, tmo);
    n_chk++; if (tmo != 0 || obs_c.size() != 512 || done_cyc.size() != 1) begin
      n_fail++; $display("FAIL full_counts got tmo%0d beats%0d done%0d want 0 512 1", tmo, obs_c.size(), done_cyc.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 512; i++)
        if (obs_f[i] !== exp_f[i] || obs_w[i] !== exp_w[i] || obs_c[i] !== exp_c[i]) bad++;
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL full_stream got %0d bad beats want 0", bad); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (obs_f[256 + i] !== obs_f[i]) bad++;
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL full_replay got %0d differing words want 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_groups();
    test_random_gaps();
    test_start_ignored();
    test_mid_reset();
    test_full_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
